// File: rtl/forwarding_scoreboard.sv
// Hazard/forwarding scoreboard: a DEPTH-slot in-flight destination pipe with per-slot
// result latency drives the decode stall, per-source forward selects and a stall counter.
module forwarding_scoreboard #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_issue_valid,
  input  logic [REG_W-1:0]         i_issue_rd,
  input  logic                     i_issue_wb,
  input  logic [SEL_W-1:0]         i_issue_lat,
  input  logic [NUM_SRC*REG_W-1:0] i_rs,
  input  logic [NUM_SRC-1:0]       i_rs_used,
  input  logic [DEPTH-1:0]         i_flush_mask,
  input  logic                     i_cnt_clr,
  output logic                     o_stall,
  output logic [NUM_SRC*SEL_W-1:0] o_fwd_sel,
  output logic [CNT_W-1:0]         o_stall_cnt
);

  localparam logic [SEL_W-1:0] LAT_MAX = SEL_W'(DEPTH - 1);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_wb;
  logic [REG_W-1:0] r_rd  [DEPTH];
  logic [SEL_W-1:0] r_lat [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic                     w_stall;
  logic                     w_any_nr;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic [SEL_W-1:0]         w_lat_cl;
  logic [REG_W-1:0]         w_src;
  logic                     w_found;
  logic                     w_m;
  logic                     w_use;
  logic                     w_nr;
  logic [SEL_W-1:0]         w_hit_k;
  logic [SEL_W-1:0]         w_hit_lat;
  logic                     w_unused_flush;

  // The oldest slot retires regardless, so killing it has no observable effect.
  assign w_unused_flush = i_flush_mask[DEPTH-1];

  assign w_lat_cl = (i_issue_lat > LAT_MAX) ? LAT_MAX : i_issue_lat;

  // Per-source youngest-producer search, readiness and forward select.
  always_comb begin
    w_any_nr  = 1'b0;
    w_fwd_sel = '0;
    w_src     = '0;
    w_found   = 1'b0;
    w_m       = 1'b0;
    w_use     = 1'b0;
    w_nr      = 1'b0;
    w_hit_k   = '0;
    w_hit_lat = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      w_src     = i_rs[j*REG_W +: REG_W];
      w_found   = 1'b0;
      w_hit_k   = '0;
      w_hit_lat = '0;
      for (int k = 0; k < DEPTH; k++) begin
        w_m       = ~w_found & r_vld[k] & r_wb[k] & (r_rd[k] == w_src) & (w_src != '0);
        w_hit_k   = w_m ? SEL_W'(k) : w_hit_k;
        w_hit_lat = w_m ? r_lat[k]  : w_hit_lat;
        w_found   = w_found | w_m;
      end
      w_use    = i_rs_used[j] & w_found;
      w_nr     = w_use & (w_hit_k < w_hit_lat);
      w_any_nr = w_any_nr | w_nr;
      w_fwd_sel[j*SEL_W +: SEL_W] = (w_use & ~w_nr) ? (w_hit_k + SEL_W'(1)) : '0;
    end
  end

  // Outputs are forced quiet while reset is held, before the slots are known.
  assign w_stall     = rst_n & i_issue_valid & w_any_nr;
  assign o_stall     = w_stall;
  assign o_fwd_sel   = rst_n ? w_fwd_sel : '0;
  assign o_stall_cnt = r_cnt;

  // In-flight slot pipe: always advances; a stall or idle decode injects a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_wb  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k]  <= '0;
        r_lat[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_issue_valid & ~w_stall;
      r_wb[0]  <= i_issue_wb;
      r_rd[0]  <= i_issue_rd;
      r_lat[0] <= w_lat_cl;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1] & ~i_flush_mask[k-1];
        r_wb[k]  <= r_wb[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_lat[k] <= r_lat[k-1];
      end
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Scoreboard bench: the driver pushes hand-computed expectations per cycle, and a
// negedge monitor pops and compares them against both DUT instances.
module tb_forwarding_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic        i_issue_wb;
  logic [1:0]  i_issue_lat;
  logic [9:0]  i_rs;
  logic [1:0]  i_rs_used;
  logic [2:0]  i_flush_mask;
  logic        i_cnt_clr;
  logic        o_stall;
  logic [3:0]  o_fwd_sel;
  logic [15:0] o_stall_cnt;
  logic        o_stall4;
  logic [3:0]  o_fwd_sel4;
  logic [3:0]  o_stall_cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    bit          cs;
    bit          st;
    bit          csel;
    logic [3:0]  sel;
    bit          cc;
    logic [15:0] cnt;
    bit          c4;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  exp_t m;

  forwarding_scoreboard u_dut (
    .clk(clk), .rst_n(rst_n), .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_issue_wb(i_issue_wb), .i_issue_lat(i_issue_lat), .i_rs(i_rs), .i_rs_used(i_rs_used),
    .i_flush_mask(i_flush_mask), .i_cnt_clr(i_cnt_clr), .o_stall(o_stall),
    .o_fwd_sel(o_fwd_sel), .o_stall_cnt(o_stall_cnt)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  forwarding_scoreboard #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_issue_wb(i_issue_wb), .i_issue_lat(i_issue_lat), .i_rs(i_rs), .i_rs_used(i_rs_used),
    .i_flush_mask(i_flush_mask), .i_cnt_clr(i_cnt_clr), .o_stall(o_stall4),
    .o_fwd_sel(o_fwd_sel4), .o_stall_cnt(o_stall_cnt4)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic exp_t ex(string n, bit cs, bit st, bit csel, logic [3:0] sel,
                              bit cc = 1'b0, logic [15:0] c = 16'd0,
                              bit c4 = 1'b0, logic [3:0] cn4 = 4'd0);
    exp_t e;
    e.name = n; e.cs = cs; e.st = st; e.csel = csel; e.sel = sel;
    e.cc = cc; e.cnt = c; e.c4 = c4; e.cnt4 = cn4;
    return e;
  endfunction

  task automatic cmp(string n, string f, logic [15:0] got, logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got %0h expected %0h", n, f, got, want);
    end
  endtask

  task automatic step(bit v, logic [4:0] rd, bit wb, logic [1:0] lat,
                      logic [4:0] r0, logic [4:0] r1, logic [1:0] used,
                      logic [2:0] fl, bit clr, exp_t e);
    i_issue_valid = v;
    i_issue_rd    = rd;
    i_issue_wb    = wb;
    i_issue_lat   = lat;
    i_rs          = {r1, r0};
    i_rs_used     = used;
    i_flush_mask  = fl;
    i_cnt_clr     = clr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m = q.pop_front();
      if (m.cs)   cmp(m.name, "stall", {15'd0, o_stall}, {15'd0, m.st});
      if (m.csel) cmp(m.name, "fwd_sel", {12'd0, o_fwd_sel}, {12'd0, m.sel});
      if (m.cc)   cmp(m.name, "cnt", o_stall_cnt, m.cnt);
      if (m.c4)   cmp(m.name, "cnt4", {12'd0, o_stall_cnt4}, {12'd0, m.cnt4});
    end
  end

  initial begin
    rst_n = 1'b0;
    // Reset held: outputs quiet even with a hazard-looking request.
    step(1, 5'd1, 1, 2'd1, 5'd1, 5'd1, 2'b11, 3'b000, 0, ex("rst1", 1, 0, 1, 4'h0));
    step(1, 5'd1, 1, 2'd1, 5'd1, 5'd1, 2'b11, 3'b000, 0, ex("rst2", 1, 0, 1, 4'h0));
    rst_n = 1'b1;
    step(0, 5'd0, 0, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("post_rst", 1, 0, 1, 4'h0, 1, 16'd0, 1, 4'd0));

    // ALU to ALU: x3 forwarded from slot 0, 1, 2, then register file.
    step(1, 5'd3,  1, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("alu_iss", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd3, 5'd0, 2'b01, 3'b000, 0, ex("alu_s0", 1, 0, 1, 4'h1));
    step(1, 5'd20, 0, 2'd0, 5'd3, 5'd0, 2'b01, 3'b000, 0, ex("alu_s1", 1, 0, 1, 4'h2));
    step(1, 5'd20, 0, 2'd0, 5'd3, 5'd0, 2'b01, 3'b000, 0, ex("alu_s2", 1, 0, 1, 4'h3));
    step(1, 5'd20, 0, 2'd0, 5'd3, 5'd0, 2'b01, 3'b000, 0, ex("alu_rf", 1, 0, 1, 4'h0, 1, 16'd0));

    // Load-use: one stall, then forward from slot 1 on source 1.
    step(1, 5'd10, 1, 2'd1, 5'd0, 5'd0,  2'b00, 3'b000, 0, ex("ld_iss", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd0, 5'd10, 2'b10, 3'b000, 0, ex("ld_use", 1, 1, 0, 4'h0, 1, 16'd0));
    step(1, 5'd20, 0, 2'd0, 5'd0, 5'd10, 2'b10, 3'b000, 0, ex("ld_fwd", 1, 0, 1, 4'h8, 1, 16'd1));

    // Youngest producer wins; x0 never matches.
    step(1, 5'd4,  1, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("yw_a", 1, 0, 1, 4'h0));
    step(1, 5'd4,  1, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("yw_b", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd4, 5'd0, 2'b01, 3'b000, 0, ex("yw_rd", 1, 0, 1, 4'h1));
    step(1, 5'd0,  1, 2'd1, 5'd0, 5'd0, 2'b11, 3'b000, 0, ex("x0_iss", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd0, 5'd0, 2'b11, 3'b000, 0, ex("x0_rd", 1, 0, 1, 4'h0));

    // Flush: the flush cycle still stalls; the killed load is gone next cycle.
    step(1, 5'd7,  1, 2'd1, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("fl_iss", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd7, 5'd0, 2'b01, 3'b001, 0, ex("fl_cyc", 1, 1, 0, 4'h0, 1, 16'd1));
    step(1, 5'd20, 0, 2'd0, 5'd7, 5'd0, 2'b01, 3'b000, 0, ex("fl_aft", 1, 0, 1, 4'h0, 1, 16'd2));

    // Both sources hazard: load x5 in slot 0 stalls, ALU x6 in slot 1.
    step(1, 5'd6,  1, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("two_a", 1, 0, 1, 4'h0));
    step(1, 5'd5,  1, 2'd1, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("two_b", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd5, 5'd6, 2'b11, 3'b000, 0, ex("two_st", 1, 1, 0, 4'h0, 1, 16'd2));
    step(1, 5'd20, 0, 2'd0, 5'd5, 5'd6, 2'b11, 3'b000, 0, ex("two_fw", 1, 0, 1, 4'hE, 1, 16'd3));
    step(1, 5'd5,  1, 2'd1, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("unused_a", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd5, 5'd5, 2'b00, 3'b000, 0, ex("unused_b", 1, 0, 1, 4'h0));

    // Non-writing entry never matches; source 1 picks x5 from slot 2.
    step(1, 5'd9,  0, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("nowb_a", 1, 0, 1, 4'h0));
    step(1, 5'd20, 0, 2'd0, 5'd9, 5'd5, 2'b11, 3'b000, 0, ex("nowb_b", 1, 0, 1, 4'hC, 1, 16'd3));

    // Counter clear, then saturation on the narrow instance with clear over increment.
    step(0, 5'd0, 0, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 1, ex("clr", 0, 0, 0, 4'h0, 1, 16'd3, 1, 4'd3));
    step(0, 5'd0, 0, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("clr_aft", 0, 0, 0, 4'h0, 1, 16'd0, 1, 4'd0));
    step(0, 5'd0, 0, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("idle", 0, 0, 0, 4'h0));
    for (int i = 0; i < 30; i++) begin
      step(1, 5'd10, 1, 2'd3, 5'd10, 5'd0, 2'b01, 3'b000, (i == 28),
           ex("sat", 1, (i % 3 != 0), (i % 3 == 0), (i == 0) ? 4'h0 : 4'h3,
              (i == 28), 16'd18, (i == 28), 4'd15));
    end
    step(0, 5'd0, 0, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("sat_aft", 1, 0, 0, 4'h0, 1, 16'd1, 1, 4'd1));

    // Reset with slots full: everything discarded.
    step(1, 5'd12, 1, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("full_a", 1, 0, 1, 4'h0));
    step(1, 5'd13, 1, 2'd1, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("full_b", 1, 0, 1, 4'h0));
    step(1, 5'd14, 1, 2'd0, 5'd0, 5'd0, 2'b00, 3'b000, 0, ex("full_c", 1, 0, 1, 4'h0));
    rst_n = 1'b0;
    step(1, 5'd20, 0, 2'd0, 5'd13, 5'd14, 2'b11, 3'b000, 0, ex("mid_rst", 1, 0, 1, 4'h0));
    rst_n = 1'b1;
    step(1, 5'd20, 0, 2'd0, 5'd12, 5'd13, 2'b11, 3'b000, 0, ex("rst_aft", 1, 0, 1, 4'h0, 1, 16'd0, 1, 4'd0));

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
